// File: rtl/slavefifo2b_out_stage.sv
// FX3 Slave FIFO 2-bit output stage: flag registering, generator arbitration
// with a drain interval between modes, registered GPIF pins and a write counter.
module slavefifo2b_out_stage #(
   parameter int DATA_W       = 32,
   parameter int DRAIN_CYCLES = 8
) (
   input  logic              clk_100,
   input  logic              reset,
   input  logic [1:0]        mode_req,
   input  logic              flaga,
   input  logic              flagb,
   output logic              flaga_d,
   output logic              flagb_d,
   output logic              partial_mode_selected,
   output logic              streamin_mode_selected,
   output logic              zlp_mode_selected,
   input  logic              slwr_partial_,
   input  logic              pktend_partial_,
   input  logic [DATA_W-1:0] data_out_partial,
   input  logic              slwr_streamin_,
   input  logic [DATA_W-1:0] data_out_streamin,
   input  logic              slwr_zlp_,
   input  logic              pktend_zlp_,
   input  logic [DATA_W-1:0] data_out_zlp,
   output logic              slcs_,
   output logic              slwr_,
   output logic              slrd_,
   output logic              sloe_,
   output logic              pktend_,
   output logic [1:0]        faddr,
   output logic [DATA_W-1:0] fdata,
   output logic [1:0]        active_mode,
   output logic              busy,
   output logic [15:0]       wr_count
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACTIVE = 2'd1;
   localparam logic [1:0] DRAIN  = 2'd2;

   localparam logic [1:0] MODE_PARTIAL  = 2'd1;
   localparam logic [1:0] MODE_STREAMIN = 2'd2;
   localparam logic [1:0] MODE_ZLP      = 2'd3;

   localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

   logic [1:0]        state, state_nxt;
   logic [1:0]        mode_req_r;
   logic [7:0]        drain_cnt;
   logic              gen_slwr, gen_pktend;
   logic [DATA_W-1:0] gen_data;

   // write-only access to socket 0
   assign slrd_ = 1'b1;
   assign sloe_ = 1'b1;
   assign faddr = 2'b00;

   assign busy                   = (state == DRAIN);
   assign partial_mode_selected  = (state == ACTIVE) && (active_mode == MODE_PARTIAL);
   assign streamin_mode_selected = (state == ACTIVE) && (active_mode == MODE_STREAMIN);
   assign zlp_mode_selected      = (state == ACTIVE) && (active_mode == MODE_ZLP);

   always_ff @(posedge clk_100 or posedge reset) begin
      if (reset) begin
         flaga_d    <= 1'b0;
         flagb_d    <= 1'b0;
         mode_req_r <= 2'd0;
      end else begin
         flaga_d    <= flaga;
         flagb_d    <= flagb;
         mode_req_r <= mode_req;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (mode_req_r != 2'd0) state_nxt = ACTIVE;
         ACTIVE:  if (mode_req_r != active_mode) state_nxt = DRAIN;
         DRAIN:   if (drain_cnt == 8'd0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_100 or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         active_mode <= 2'd0;
         drain_cnt   <= 8'd0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && state_nxt == ACTIVE)
            active_mode <= mode_req_r;
         else if (state == DRAIN && state_nxt == IDLE)
            active_mode <= 2'd0;
         if (state == ACTIVE && state_nxt == DRAIN)
            drain_cnt <= DRAIN_LOAD;
         else if (state == DRAIN && drain_cnt != 8'd0)
            drain_cnt <= drain_cnt - 8'd1;
      end
   end

   // stream-in stage has no packet-end strobe
   always_comb begin
      gen_slwr   = 1'b1;
      gen_pktend = 1'b1;
      gen_data   = '0;
      case (active_mode)
         MODE_PARTIAL: begin
            gen_slwr   = slwr_partial_;
            gen_pktend = pktend_partial_;
            gen_data   = data_out_partial;
         end
         MODE_STREAMIN: begin
            gen_slwr   = slwr_streamin_;
            gen_data   = data_out_streamin;
         end
         MODE_ZLP: begin
            gen_slwr   = slwr_zlp_;
            gen_pktend = pktend_zlp_;
            gen_data   = data_out_zlp;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_100 or posedge reset) begin
      if (reset) begin
         slcs_   <= 1'b1;
         slwr_   <= 1'b1;
         pktend_ <= 1'b1;
         fdata   <= '0;
      end else begin
         slcs_ <= (state_nxt == IDLE);
         if (state == ACTIVE) begin
            slwr_   <= gen_slwr;
            pktend_ <= gen_pktend;
            fdata   <= gen_data;
         end else begin
            slwr_   <= 1'b1;
            pktend_ <= 1'b1;
         end
      end
   end

   // counts strobes actually presented on the pin, per mode session
   always_ff @(posedge clk_100 or posedge reset) begin
      if (reset)
         wr_count <= 16'd0;
      else if (state == IDLE && state_nxt == ACTIVE)
         wr_count <= 16'd0;
      else if (!slwr_ && wr_count != 16'hFFFF)
         wr_count <= wr_count + 16'd1;
   end

endmodule

// File: tb/tb_slavefifo2b_out_stage.sv
// Directed bench for slavefifo2b_out_stage: table-driven partial burst plus
// hand-written sequences for mode switching, drain, saturation and reset.
module tb_slavefifo2b_out_stage;

   localparam int DATA_W = 32;
   localparam int DRAIN  = 8;

   logic              clk_100 = 1'b0;
   logic              reset;
   logic [1:0]        mode_req;
   logic              flaga, flagb;
   logic              flaga_d, flagb_d;
   logic              partial_mode_selected, streamin_mode_selected, zlp_mode_selected;
   logic              slwr_partial_, pktend_partial_;
   logic [DATA_W-1:0] data_out_partial;
   logic              slwr_streamin_;
   logic [DATA_W-1:0] data_out_streamin;
   logic              slwr_zlp_, pktend_zlp_;
   logic [DATA_W-1:0] data_out_zlp;
   logic              slcs_, slwr_, slrd_, sloe_, pktend_;
   logic [1:0]        faddr;
   logic [DATA_W-1:0] fdata;
   logic [1:0]        active_mode;
   logic              busy;
   logic [15:0]       wr_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_100 = ~clk_100;

   slavefifo2b_out_stage #(.DATA_W(DATA_W), .DRAIN_CYCLES(DRAIN)) dut (
      .clk_100(clk_100), .reset(reset), .mode_req(mode_req),
      .flaga(flaga), .flagb(flagb), .flaga_d(flaga_d), .flagb_d(flagb_d),
      .partial_mode_selected(partial_mode_selected),
      .streamin_mode_selected(streamin_mode_selected),
      .zlp_mode_selected(zlp_mode_selected),
      .slwr_partial_(slwr_partial_), .pktend_partial_(pktend_partial_),
      .data_out_partial(data_out_partial),
      .slwr_streamin_(slwr_streamin_), .data_out_streamin(data_out_streamin),
      .slwr_zlp_(slwr_zlp_), .pktend_zlp_(pktend_zlp_), .data_out_zlp(data_out_zlp),
      .slcs_(slcs_), .slwr_(slwr_), .slrd_(slrd_), .sloe_(sloe_), .pktend_(pktend_),
      .faddr(faddr), .fdata(fdata), .active_mode(active_mode), .busy(busy),
      .wr_count(wr_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_100);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " flaga_d"}, 32'(flaga_d), 0);
      chk({tag, " flagb_d"}, 32'(flagb_d), 0);
      chk({tag, " selects"}, 32'({partial_mode_selected, streamin_mode_selected, zlp_mode_selected}), 0);
      chk({tag, " active_mode"}, 32'(active_mode), 0);
      chk({tag, " busy"}, 32'(busy), 0);
      chk({tag, " ctl pins"}, 32'({slcs_, slwr_, slrd_, sloe_, pktend_}), 32'h1F);
      chk({tag, " faddr"}, 32'(faddr), 0);
      chk({tag, " fdata"}, fdata, 0);
      chk({tag, " wr_count"}, 32'(wr_count), 0);
   endtask

   typedef struct {
      logic        slwr_in;
      logic        pktend_in;
      logic [31:0] data_in;
      logic        exp_slwr;
      logic        exp_pktend;
      logic [31:0] exp_fdata;
      logic [15:0] exp_wr_count;
   } vec_t;

   vec_t vecs[18];

   initial begin
      int hi_cnt, slcs_hi, busy_cnt, zlp_seen, k;
      bit found;

      for (int i = 0; i < 16; i++)
         vecs[i] = '{1'b0, 1'b1, 32'(i), 1'b0, 1'b1, 32'(i), 16'(i)};
      vecs[16] = '{1'b1, 1'b0, 32'hAB, 1'b1, 1'b0, 32'hAB, 16'd16};
      vecs[17] = '{1'b1, 1'b1, 32'hAB, 1'b1, 1'b1, 32'hAB, 16'd16};

      reset = 1'b1; mode_req = 2'd1; flaga = 1'b1; flagb = 1'b1;
      slwr_partial_ = 1'b1; pktend_partial_ = 1'b1; data_out_partial = '0;
      slwr_streamin_ = 1'b1; data_out_streamin = '0;
      slwr_zlp_ = 1'b1; pktend_zlp_ = 1'b1; data_out_zlp = '0;

      // reset and start-up latency
      step(); step();
      chk_reset_vals("reset");
      reset = 1'b0;
      step();
      chk("flaga_d after 1 edge", 32'(flaga_d), 1);
      chk("partial sel after 1 edge", 32'(partial_mode_selected), 0);
      step();
      chk("partial sel after 2 edges", 32'(partial_mode_selected), 1);
      chk("active_mode partial", 32'(active_mode), 1);
      chk("slcs_ in ACTIVE", 32'(slcs_), 0);
      chk("wr_count at start", 32'(wr_count), 0);

      // partial burst: 16 writes then pktend
      for (int i = 0; i < 18; i++) begin
         slwr_partial_ = vecs[i].slwr_in;
         pktend_partial_ = vecs[i].pktend_in;
         data_out_partial = vecs[i].data_in;
         step();
         chk($sformatf("burst[%0d] slwr_", i), 32'(slwr_), 32'(vecs[i].exp_slwr));
         chk($sformatf("burst[%0d] pktend_", i), 32'(pktend_), 32'(vecs[i].exp_pktend));
         chk($sformatf("burst[%0d] fdata", i), fdata, vecs[i].exp_fdata);
         chk($sformatf("burst[%0d] wr_count", i), 32'(wr_count), 32'(vecs[i].exp_wr_count));
      end

      // switch 1 -> 2 mid-burst
      slwr_partial_ = 1'b0; data_out_partial = 32'h1111_0000;
      slwr_streamin_ = 1'b0; data_out_streamin = 32'h5000_0000;
      step(); step();
      mode_req = 2'd2;
      step();
      chk("partial sel held at M", 32'(partial_mode_selected), 1);
      step();
      chk("partial sel dropped", 32'(partial_mode_selected), 0);
      chk("busy in drain", 32'(busy), 1);
      chk("last strobe captured", 32'(slwr_), 0);
      chk("slcs_ in drain", 32'(slcs_), 0);
      hi_cnt = 0; slcs_hi = 0; found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         step();
         if (slwr_) begin
            hi_cnt++;
            if (slcs_) slcs_hi++;
         end else found = 1;
      end
      chk("switch gap found", 32'(found), 1);
      chk("slwr_ high gap", 32'(hi_cnt), DRAIN + 1);
      chk("idle slcs_ cycles", 32'(slcs_hi), 1);
      chk("streamin sel", 32'(streamin_mode_selected), 1);
      chk("streamin pktend_", 32'(pktend_), 1);
      chk("streamin fdata", fdata, 32'h5000_0000);

      // 2 -> 3 -> 2 around the drain: zlp never selected
      mode_req = 2'd3;
      busy_cnt = 0; zlp_seen = 0; found = 0; k = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         step();
         k++;
         if (k == 3) mode_req = 2'd2;
         if (busy) busy_cnt++;
         if (zlp_mode_selected) zlp_seen++;
         if (k > 2 && streamin_mode_selected) found = 1;
      end
      chk("re-entered streamin", 32'(found), 1);
      chk("zlp never selected", 32'(zlp_seen), 0);
      chk("drain length", 32'(busy_cnt), DRAIN);
      chk("active_mode streamin", 32'(active_mode), 2);
      chk("wr_count cleared on entry", 32'(wr_count), 0);

      // saturation
      for (int i = 0; i < 70000; i++) @(posedge clk_100);
      #1;
      chk("wr_count saturated", 32'(wr_count), 32'hFFFF);
      slwr_streamin_ = 1'b1;
      mode_req = 2'd0;
      for (int i = 0; i < DRAIN + 4; i++) step();
      chk("idle after mode 0", 32'(active_mode), 0);
      chk("idle slcs_", 32'(slcs_), 1);
      chk("wr_count held in idle", 32'(wr_count), 32'hFFFF);
      slwr_partial_ = 1'b1;
      mode_req = 2'd1;
      step();
      step();
      chk("re-entry partial sel", 32'(partial_mode_selected), 1);
      chk("wr_count cleared", 32'(wr_count), 0);

      // asynchronous reset mid-write
      slwr_partial_ = 1'b0; data_out_partial = 32'hDEAD_BEEF;
      step(); step();
      chk("pre-reset slwr_", 32'(slwr_), 0);
      chk("pre-reset fdata", fdata, 32'hDEAD_BEEF);
      #2 reset = 1'b1;
      #1;
      chk_reset_vals("async reset");
      step();
      reset = 1'b0;
      step();
      chk("restart sel after 1 edge", 32'(partial_mode_selected), 0);
      step();
      chk("restart partial sel", 32'(partial_mode_selected), 1);
      step();
      chk("restart slwr_", 32'(slwr_), 0);
      chk("restart fdata", fdata, 32'hDEAD_BEEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/slavefifo2b_out_stage.md
# slavefifo2b_out_stage

Output stage for the FX3 Slave FIFO 2-bit interface that sits directly downstream of the mode generators: the partial, stream-in and ZLP stages. It registers the raw FX3 flags for the generators and arbitrates which generator owns the bus. Mode changes go through a drain interval, and every pin driven to the FX3 GPIF comes from a register. It also keeps a saturating count of committed write strobes per mode session.

## Interface
- DATA_W, 32, width of fdata and of each generator data bus
- DRAIN_CYCLES, 8, cycles the bus is held inactive between modes (1..255)
- clk_100  in  1  interface clock, all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- mode_req  in  2  requested mode: 0 none, 1 partial, 2 stream-in, 3 ZLP
- flaga, flagb  in  1 each  raw FX3 flags (full / partial-full, active-high = space available)
- flaga_d, flagb_d  out  1 each  flaga/flagb registered one cycle, to generators
- partial_mode_selected, streamin_mode_selected, zlp_mode_selected  out  1 each  one-hot enable to generators
- slwr_partial_, pktend_partial_  in  1 each  partial-stage strobes, active-low
- data_out_partial  in  DATA_W  partial-stage data
- slwr_streamin_  in  1  stream-in write strobe, active-low
- data_out_streamin  in  DATA_W  stream-in data
- slwr_zlp_, pktend_zlp_  in  1 each  ZLP-stage strobes, active-low
- data_out_zlp  in  DATA_W  ZLP-stage data
- slcs_, slwr_, slrd_, sloe_, pktend_  out  1 each  FX3 controls, active-low
- faddr  out  2  FX3 socket address
- fdata  out  DATA_W  FX3 data bus
- active_mode  out  2  mode currently owning the bus (0 when none)
- busy  out  1  high in DRAIN
- wr_count  out  16  committed slwr_ strobes since entering ACTIVE

## Operation
- mode_req is registered into mode_req_r every cycle. The FSM acts only on mode_req_r.
- IDLE: all selects low, active_mode=0. If mode_req_r≠0, latch active_mode←mode_req_r, clear wr_count, go to ACTIVE.
- ACTIVE: the select matching active_mode is high and the other two are low.
  - If mode_req_r≠active_mode, drop all selects, load drain counter with DRAIN_CYCLES-1, go to DRAIN.
- DRAIN: selects low, busy=1, counter decrements each cycle. At 0 go to IDLE. mode_req_r is ignored while draining.
- Output mux, registered:
  - slwr_/pktend_/fdata take the generator signals selected by active_mode, only while state=ACTIVE.
  - In any other state: slwr_=1, pktend_=1, fdata holds its last value.
  - The stream-in stage has no pktend, so in mode 2 pktend_=1.
- slcs_=0 in ACTIVE and DRAIN, 1 in IDLE. slrd_=1, sloe_=1 and faddr=2'b00 constantly (write-only, socket 0).
- wr_count increments by 1 on each cycle the registered slwr_ is 0.
  - It saturates at 16'hFFFF and does not wrap.
  - It clears only on IDLE→ACTIVE and holds through DRAIN/IDLE.

## Timing
- Reset values: flaga_d=0, flagb_d=0, all selects 0, active_mode=0, busy=0, slcs_=slwr_=slrd_=sloe_=pktend_=1, faddr=0, fdata=0, wr_count=0, state IDLE.
- Flag latency: flaga→flaga_d is 1 cycle.
- Mode start: mode_req set before edge N, mode_req_r at N, ACTIVE and select high after N+1.
- Data latency: a generator slwr_ low in cycle k gives pin slwr_ low in cycle k+1, with fdata aligned in the same cycle.
- Mode stop: mode_req change seen in mode_req_r at edge M. Select falls after M+1; the pin slwr_ strobe captured at M+1 is the last possible one.
  - DRAIN lasts exactly DRAIN_CYCLES cycles, then IDLE for 1 cycle, then ACTIVE in the new mode if it is still requested.
  - Minimum gap between modes is DRAIN_CYCLES+1 cycles with slwr_ high.
- A request to mode 0 from ACTIVE drains and then stays in IDLE.
- A request that changes mid-DRAIN takes effect only at IDLE.
- An asynchronous reset mid-ACTIVE returns all outputs to their reset values immediately. A truncated packet is not terminated with pktend_.

## Test plan
- Reset with mode_req=1, flaga=flagb=1: all outputs at reset values. After release, partial_mode_selected=1 two edges later, and flaga_d=1 one edge after release.
- Partial mode, generator drives 16 slwr_ lows with data 0..15 and then a pktend_ low: pins show the same sequence one cycle later, and wr_count=16.
- Switch mode_req 1→2 in the middle of a write burst: partial select falls, pin slwr_ is high for exactly DRAIN_CYCLES+1 cycles, then streamin_mode_selected=1. pktend_ stays 1 in mode 2.
- Toggle mode_req 2→3→2 during DRAIN: the FSM finishes the drain, then enters ACTIVE in mode 2, and zlp_mode_selected never asserts.
- Hold slwr_streamin_ low for 70000 cycles: wr_count saturates at 16'hFFFF. Re-entering ACTIVE clears it to 0.
- Assert reset during ACTIVE with slwr_ low: slwr_, pktend_ and slcs_ read 1 and fdata reads 0 in the same cycle. Normal restart follows after reset release.
